// File: rtl/ladybird_axi_port_arbiter_if.sv
// AXI4 signal bundle between the port arbiter (master) and the system interconnect (slave).
interface ladybird_axi_interface #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
);
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [AXI_ID_W-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [AXI_ID_W-1:0]     rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/ladybird_axi_port_arbiter.sv
// Round-robin arbiter of N load/store requesters onto one AXI4 master, one transaction in flight.
// Optional LADYBIRD_AXI_RESP_ERR_EN: also flag SLVERR/DECERR read/write responses on o_err.
module ladybird_axi_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int XLEN    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS-1:0]           i_valid,
    output logic [N_PORTS-1:0]           i_ready,
    input  logic [N_PORTS-1:0][XLEN-1:0] i_addr,
    input  logic [N_PORTS-1:0][XLEN-1:0] i_data,
    input  logic [N_PORTS-1:0]           i_we,
    input  logic [N_PORTS-1:0][2:0]      i_funct,
    output logic [N_PORTS-1:0]           o_valid,
    input  logic [N_PORTS-1:0]           o_ready,
    output logic [XLEN-1:0]              o_data,
    output logic                         o_err,
    ladybird_axi_interface.master        axi
);
    localparam int OW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B,
        S_ERR
    } state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [XLEN-1:0] addr_reg, addr_next;
    logic [XLEN-1:0] data_reg, data_next;
    logic            we_reg, we_next;
    logic [2:0]      funct_reg, funct_next;
    logic            aw_done_reg, aw_done_next;
    logic            w_done_reg, w_done_next;

    function automatic logic [OW-1:0] port_add(input logic [OW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_PORTS) begin
            sum = sum - N_PORTS;
        end
        return OW'(sum);
    endfunction

    // Rotate the request vector so that rr_ptr sits at bit 0; the lowest set bit wins.
    logic [2*N_PORTS-1:0] valid_dbl;
    logic [N_PORTS-1:0]   valid_rot;
    logic [OW-1:0]        grant_idx;
    logic                 grant_any;

    assign valid_dbl = {i_valid, i_valid};
    assign valid_rot = valid_dbl[rr_ptr_reg +: N_PORTS];

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_any = 1'b1;
                grant_idx = port_add(rr_ptr_reg, k);
            end
        end
    end

    logic req_misaligned;
    always_comb begin
        req_misaligned = 1'b0;
        case (i_funct[grant_idx][1:0])
            2'b01:   req_misaligned = i_addr[grant_idx][0];
            2'b10:   req_misaligned = |i_addr[grant_idx][1:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    logic owner_rdy;
    logic aw_hs, w_hs, ar_hs, r_hs, b_hs;
    assign owner_rdy = o_ready[owner_reg];
    assign aw_hs     = axi.awvalid & axi.awready;
    assign w_hs      = axi.wvalid & axi.wready;
    assign ar_hs     = axi.arvalid & axi.arready;
    assign r_hs      = axi.rvalid & axi.rready & axi.rlast;
    assign b_hs      = axi.bvalid & axi.bready;

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        rr_ptr_next  = rr_ptr_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        we_next      = we_reg;
        funct_next   = funct_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_any) begin
                    owner_next   = grant_idx;
                    rr_ptr_next  = port_add(grant_idx, 1);
                    addr_next    = i_addr[grant_idx];
                    data_next    = i_data[grant_idx];
                    we_next      = i_we[grant_idx];
                    funct_next   = i_funct[grant_idx];
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    if (req_misaligned) begin
                        state_next = S_ERR;
                    end else if (i_we[grant_idx]) begin
                        state_next = S_AWW;
                    end else begin
                        state_next = S_AR;
                    end
                end
            end
            S_AR: begin
                if (ar_hs) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                if (r_hs) begin
                    state_next = S_IDLE;
                end
            end
            S_AWW: begin
                // Address and data channels finish in any order, possibly together.
                aw_done_next = aw_done_reg | aw_hs;
                w_done_next  = w_done_reg | w_hs;
                if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
                    state_next = S_B;
                end
            end
            S_B: begin
                if (b_hs) begin
                    state_next = S_IDLE;
                end
            end
            S_ERR: begin
                if (owner_rdy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            owner_reg   <= '0;
            rr_ptr_reg  <= '0;
            addr_reg    <= '0;
            data_reg    <= '0;
            we_reg      <= 1'b0;
            funct_reg   <= 3'b000;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_ptr_reg  <= rr_ptr_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            we_reg      <= we_next;
            funct_reg   <= funct_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    logic resp_valid;
    always_comb begin
        resp_valid = 1'b0;
        case (state_reg)
            S_R:     resp_valid = axi.rvalid;
            S_B:     resp_valid = axi.bvalid;
            S_ERR:   resp_valid = 1'b1;
            default: resp_valid = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign i_ready[gi] = (state_reg == S_IDLE) && !rst && grant_any && (grant_idx == OW'(gi));
            assign o_valid[gi] = resp_valid && (owner_reg == OW'(gi));
        end
    endgenerate

    // Load formatting: bring the addressed lane down to bit 0, then extend.
    logic [XLEN-1:0] load_lane;
    always_comb begin
        load_lane = axi.rdata >> {addr_reg[1:0], 3'b000};
        o_data    = '0;
        if (state_reg == S_R) begin
            case (funct_reg)
                3'b000:  o_data = {{(XLEN-8){load_lane[7]}}, load_lane[7:0]};
                3'b001:  o_data = {{(XLEN-16){load_lane[15]}}, load_lane[15:0]};
                3'b100:  o_data = {{(XLEN-8){1'b0}}, load_lane[7:0]};
                3'b101:  o_data = {{(XLEN-16){1'b0}}, load_lane[15:0]};
                default: o_data = axi.rdata;
            endcase
        end
    end

    always_comb begin
        o_err = (state_reg == S_ERR);
`ifdef LADYBIRD_AXI_RESP_ERR_EN
        if (state_reg == S_R) begin
            o_err = axi.rvalid & axi.rresp[1];
        end
        if (state_reg == S_B) begin
            o_err = axi.bvalid & axi.bresp[1];
        end
`endif
    end

    always_comb begin
        axi.arid            = '0;
        axi.arid[OW-1:0]    = owner_reg;
        axi.awid            = '0;
        axi.awid[OW-1:0]    = owner_reg;
    end

    assign axi.arvalid = (state_reg == S_AR);
    assign axi.araddr  = {addr_reg[XLEN-1:2], 2'b00};
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.rready  = (state_reg == S_R) && owner_rdy;

    assign axi.awvalid = (state_reg == S_AWW) && !aw_done_reg;
    assign axi.awaddr  = {addr_reg[XLEN-1:2], 2'b00};
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;

    assign axi.wvalid  = (state_reg == S_AWW) && !w_done_reg;
    assign axi.wdata   = data_reg << {addr_reg[1:0], 3'b000};
    assign axi.wlast   = 1'b1;
    always_comb begin
        case (funct_reg[1:0])
            2'b00:   axi.wstrb = 4'b0001 << addr_reg[1:0];
            2'b01:   axi.wstrb = 4'b0011 << addr_reg[1:0];
            default: axi.wstrb = 4'b1111;
        endcase
    end

    assign axi.bready  = (state_reg == S_B) && owner_rdy;

    // IDs are implied by the single outstanding transaction; response codes only matter with the option.
    logic unused_axi_in;
    assign unused_axi_in = ^{axi.rid, axi.bid, axi.rresp, axi.bresp, we_reg};
endmodule

// File: tb/tb_ladybird_axi_port_arbiter.sv
// Directed bench for ladybird_axi_port_arbiter with three ports and a hand-driven AXI slave.
`timescale 1ns/1ps
module tb_ladybird_axi_port_arbiter;
    localparam int N = 3;

`ifdef LADYBIRD_AXI_RESP_ERR_EN
    localparam logic RESP_ERR = 1'b1;
`else
    localparam logic RESP_ERR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          i_valid;
    logic [N-1:0]          i_ready;
    logic [N-1:0][31:0]    i_addr;
    logic [N-1:0][31:0]    i_data;
    logic [N-1:0]          i_we;
    logic [N-1:0][2:0]     i_funct;
    logic [N-1:0]          o_valid;
    logic [N-1:0]          o_ready;
    logic [31:0]           o_data;
    logic                  o_err;

    always #5 clk = ~clk;

    ladybird_axi_interface #(.AXI_ID_W(4)) axi_bus ();

    ladybird_axi_port_arbiter #(.N_PORTS(N), .XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_we    (i_we),
        .i_funct (i_funct),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_err   (o_err),
        .axi     (axi_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        mis;
        logic [31:0] exp_data;   // o_data for loads, wdata for stores
        logic [3:0]  exp_strb;
        logic [31:0] exp_araddr;
    } vec_t;

    function automatic vec_t mk(input int port, input logic we, input logic [2:0] funct,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] rdata, input logic [1:0] resp, input logic mis,
                                input logic [31:0] exp_data, input logic [3:0] exp_strb,
                                input logic [31:0] exp_araddr);
        vec_t v;
        v.port = port; v.we = we; v.funct = funct; v.addr = addr; v.data = data;
        v.rdata = rdata; v.resp = resp; v.mis = mis; v.exp_data = exp_data;
        v.exp_strb = exp_strb; v.exp_araddr = exp_araddr;
        return v;
    endfunction

    task automatic slave_idle();
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        axi_bus.bvalid  = 1'b0; axi_bus.bresp  = 2'b00; axi_bus.bid = '0;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0; axi_bus.rdata  = '0; axi_bus.rresp = 2'b00;
        axi_bus.rlast   = 1'b0; axi_bus.rid    = '0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        logic [N-1:0] oh;
        logic [31:0]  seen_data;
        logic         seen_err;
        logic         exp_err;
        oh = '0;
        oh[v.port] = 1'b1;
        exp_err = v.mis | (v.resp[1] & RESP_ERR);
        @(negedge clk);
        i_valid = oh;
        i_we[v.port] = v.we; i_funct[v.port] = v.funct;
        i_addr[v.port] = v.addr; i_data[v.port] = v.data;
        #1 chk("i_ready_grant", 32'(i_ready), 32'(oh));
        @(negedge clk);
        i_valid = '0;
        #1;
        if (v.mis) begin
            chk("err_no_axi", 32'({axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid}), 32'd0);
            chk("err_o_valid", 32'(o_valid), 32'(oh));
            seen_data = o_data; seen_err = o_err;
            o_ready = oh;
            @(negedge clk);
            o_ready = '0;
        end else if (!v.we) begin
            chk("arvalid", 32'(axi_bus.arvalid), 32'd1);
            chk("araddr", axi_bus.araddr, v.exp_araddr);
            chk("arid", 32'(axi_bus.arid), 32'(v.port));
            axi_bus.arready = 1'b1;
            @(negedge clk);
            axi_bus.arready = 1'b0;
            axi_bus.rvalid = 1'b1; axi_bus.rlast = 1'b1;
            axi_bus.rdata = v.rdata; axi_bus.rresp = v.resp;
            o_ready = oh;
            #1;
            chk("load_o_valid", 32'(o_valid), 32'(oh));
            chk("load_rready", 32'(axi_bus.rready), 32'd1);
            seen_data = o_data; seen_err = o_err;
            @(negedge clk);
            slave_idle();
            o_ready = '0;
        end else begin
            chk("aw_w_valid", 32'({axi_bus.awvalid, axi_bus.wvalid}), 32'd3);
            chk("wdata", axi_bus.wdata, v.exp_data);
            chk("wstrb", 32'(axi_bus.wstrb), 32'(v.exp_strb));
            chk("awid", 32'(axi_bus.awid), 32'(v.port));
            axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
            @(negedge clk);
            axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
            axi_bus.bvalid = 1'b1; axi_bus.bresp = v.resp;
            o_ready = oh;
            #1;
            chk("store_aw_w_dropped", 32'({axi_bus.awvalid, axi_bus.wvalid}), 32'd0);
            chk("store_o_valid", 32'(o_valid), 32'(oh));
            seen_data = o_data; seen_err = o_err;
            @(negedge clk);
            slave_idle();
            o_ready = '0;
        end
        chk("resp_o_data", seen_data, (v.we || v.mis) ? 32'd0 : v.exp_data);
        chk("resp_o_err", 32'(seen_err), 32'(exp_err));
        #1 chk("post_o_valid", 32'(o_valid), 32'd0);
        $display("txn %0d: port %0d we=%0d funct=%0d addr=0x%08h o_data=0x%08h o_err=%0d",
                 n, v.port, v.we, v.funct, v.addr, seen_data, seen_err);
    endtask

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(0, 1'b0, 3'b100, 32'h104, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 32'h00000001, 4'h0, 32'h104);
        vecs[1]  = mk(0, 1'b0, 3'b000, 32'h107, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 32'hFFFFFF80, 4'h0, 32'h104);
        vecs[2]  = mk(1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 32'hFFFF80FF, 4'h0, 32'h100);
        vecs[3]  = mk(2, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 32'h00007F01, 4'h0, 32'h100);
        vecs[4]  = mk(1, 1'b0, 3'b010, 32'h108, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 32'hDEADBEEF, 4'h0, 32'h108);
        vecs[5]  = mk(2, 1'b0, 3'b000, 32'h105, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 32'h0000007F, 4'h0, 32'h104);
        vecs[6]  = mk(0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 2'b00, 1'b0, 32'hA5000000, 4'b1000, 32'h0);
        vecs[7]  = mk(1, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 2'b00, 1'b0, 32'hABCD0000, 4'b1100, 32'h0);
        vecs[8]  = mk(2, 1'b1, 3'b010, 32'h300, 32'h12345678, 32'h0, 2'b00, 1'b0, 32'h12345678, 4'b1111, 32'h0);
        vecs[9]  = mk(0, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 4'h0, 32'h0);
        vecs[10] = mk(1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, 4'h0, 32'h0);
        vecs[11] = mk(2, 1'b1, 3'b010, 32'h302, 32'h55AA55AA, 32'h0, 2'b00, 1'b1, 32'h0, 4'h0, 32'h0);
        vecs[12] = mk(0, 1'b0, 3'b010, 32'h000, 32'h0, 32'h11223344, 2'b10, 1'b0, 32'h11223344, 4'h0, 32'h000);
        vecs[13] = mk(1, 1'b1, 3'b010, 32'h010, 32'h0BADF00D, 32'h0, 2'b11, 1'b0, 32'h0BADF00D, 4'b1111, 32'h0);

        rst = 1'b1;
        i_valid = '0; i_we = '0; i_addr = '0; i_data = '0; i_funct = '0; o_ready = '0;
        slave_idle();

        // Reset state, with a request pending to show nothing leaks out.
        @(negedge clk);
        i_valid = 3'b001;
        @(negedge clk);
        #1;
        chk("rst_arvalid", 32'(axi_bus.arvalid), 32'd0);
        chk("rst_aw_w_valid", 32'({axi_bus.awvalid, axi_bus.wvalid}), 32'd0);
        chk("rst_r_b_ready", 32'({axi_bus.rready, axi_bus.bready}), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_err", 32'(o_err), 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        i_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Round robin with all three ports requesting; port 1 stores, others load.
        @(negedge clk);
        i_valid = 3'b111; i_we = 3'b010;
        for (int p = 0; p < N; p++) begin
            i_funct[p] = 3'b010; i_addr[p] = 32'h0; i_data[p] = 32'h5A5A0000 + p;
        end
        for (int t = 0; t < 6; t++) begin
            int g;
            logic [N-1:0] goh;
            g = t % N;
            goh = '0;
            goh[g] = 1'b1;
            #1 chk("rr_i_ready", 32'(i_ready), 32'(goh));
            @(negedge clk);
            #1;
            if (g == 1) begin
                chk("rr_awid", 32'(axi_bus.awid), 32'(g));
                axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
            end else begin
                chk("rr_arid", 32'(axi_bus.arid), 32'(g));
                axi_bus.arready = 1'b1;
            end
            @(negedge clk);
            slave_idle();
            if (g == 1) begin
                axi_bus.bvalid = 1'b1;
            end else begin
                axi_bus.rvalid = 1'b1; axi_bus.rlast = 1'b1; axi_bus.rdata = 32'h0;
            end
            o_ready = 3'b111;
            #1 chk("rr_o_valid", 32'(o_valid), 32'(goh));
            $display("rr txn %0d: granted port %0d", t, g);
            @(negedge clk);
            slave_idle();
            o_ready = '0;
            if (t == 5) begin
                i_valid = '0;
            end
        end
        i_we = '0;

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

        // SH with the address handshake three cycles after the data handshake.
        @(negedge clk);
        i_valid = 3'b010; i_we[1] = 1'b1; i_funct[1] = 3'b001;
        i_addr[1] = 32'h202; i_data[1] = 32'h0000ABCD;
        @(negedge clk);
        i_valid = '0;
        o_ready = 3'b010;
        #1;
        chk("sh_wdata", axi_bus.wdata, 32'hABCD0000);
        chk("sh_wstrb", 32'(axi_bus.wstrb), 32'h0000000C);
        axi_bus.wready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            axi_bus.wready = 1'b0;
            #1;
            chk("sh_wvalid_dropped", 32'(axi_bus.wvalid), 32'd0);
            chk("sh_awvalid_held", 32'(axi_bus.awvalid), 32'd1);
            chk("sh_no_bready", 32'(axi_bus.bready), 32'd0);
            if (c == 2) begin
                axi_bus.awready = 1'b1;
            end
        end
        @(negedge clk);
        axi_bus.awready = 1'b0;
        axi_bus.bvalid = 1'b1;
        #1;
        chk("sh_awvalid_dropped", 32'(axi_bus.awvalid), 32'd0);
        chk("sh_bready", 32'(axi_bus.bready), 32'd1);
        chk("sh_o_valid", 32'(o_valid), 32'd2);
        chk("sh_o_data", o_data, 32'd0);
        $display("sh delayed-aw txn: o_valid=%b o_data=0x%08h", o_valid, o_data);
        @(negedge clk);
        slave_idle();
        o_ready = '0;
        i_we = '0;

        // Misaligned LW: error response held while o_ready stays low.
        @(negedge clk);
        i_valid = 3'b001; i_funct[0] = 3'b010; i_addr[0] = 32'h101;
        @(negedge clk);
        i_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("err_hold_no_ar", 32'(axi_bus.arvalid), 32'd0);
            chk("err_hold_o_valid", 32'(o_valid), 32'd1);
            chk("err_hold_o_err", 32'(o_err), 32'd1);
            @(negedge clk);
        end
        o_ready = 3'b001;
        @(negedge clk);
        o_ready = '0;
        #1;
        chk("err_cleared_o_valid", 32'(o_valid), 32'd0);
        chk("err_cleared_o_err", 32'(o_err), 32'd0);
        $display("err hold txn: released after 4 cycles");

        // Reset while a read response is pending.
        @(negedge clk);
        i_valid = 3'b001; i_funct[0] = 3'b010; i_addr[0] = 32'h40;
        @(negedge clk);
        i_valid = '0;
        axi_bus.arready = 1'b1;
        @(negedge clk);
        axi_bus.arready = 1'b0;
        axi_bus.rvalid = 1'b1; axi_bus.rlast = 1'b1; axi_bus.rdata = 32'hCAFEF00D;
        o_ready = 3'b001;
        #1 chk("pre_rst_rready", 32'(axi_bus.rready), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_rready", 32'(axi_bus.rready), 32'd0);
        chk("async_rst_o_valid", 32'(o_valid), 32'd0);
        chk("async_rst_arvalid", 32'(axi_bus.arvalid), 32'd0);
        chk("async_rst_o_data", o_data, 32'd0);
        @(negedge clk);
        slave_idle();
        o_ready = '0;
        rst = 1'b0;
        #1;
        i_valid = 3'b011;
        i_funct[1] = 3'b010; i_addr[1] = 32'h0;
        #1 chk("post_rst_grant", 32'(i_ready), 32'd1);
        i_valid = '0;
        $display("reset txn: grant after reset = %b", 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
